// File: rtl/audio_in_pkg.sv
// Shared types and constants for the audio input frame scheduler.
// The channel-index width helper keeps every block agreeing on how m_chan is sized.
package audio_in_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_STREAM,
      S_POP,
      S_SETTLE
   } sched_state_e;

   localparam int SETTLE_CYCLES = 2;

   // Width of a channel index; never narrower than one bit.
   function automatic int chan_idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/audio_chan_pick.sv
// Combinational channel picker: returns the lowest set mask bit, either overall
// or strictly above idx.
module audio_chan_pick
   import audio_in_pkg::*;
#(
   parameter int N = 24,
   parameter int W = chan_idx_w(N)
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] idx,
   input  logic         above,
   output logic [W-1:0] next_idx,
   output logic         found
);

   // Scan downwards so the lowest qualifying bit is the one that sticks.
   always_comb begin
      next_idx = '0;
      found    = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i] && (!above || (i > int'(idx)))) begin
            next_idx = W'(i);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/audio_in_sched.sv
// Frame scheduler: snapshots a buffered multichannel frame, streams enabled
// channels over valid/ready, pops the buffer once, and counts overflow edges.
module audio_in_sched
   import audio_in_pkg::*;
#(
   parameter int NUM_AUDIO_CHANNELS = 24,
   parameter int AUDIO_WIDTH        = 24,
   parameter int OVF_CNT_WIDTH      = 16
) (
   input  logic                                      sys_clk,
   input  logic                                      sys_rst,
   input  logic                                      enable,
   input  logic [NUM_AUDIO_CHANNELS-1:0]             chan_mask,
   input  logic                                      buf_ready,
   input  logic                                      buf_full,
   input  logic [AUDIO_WIDTH-1:0]                    buf_data [NUM_AUDIO_CHANNELS],
   output logic                                      buf_read_enable,
   output logic                                      m_valid,
   input  logic                                      m_ready,
   output logic [AUDIO_WIDTH-1:0]                    m_data,
   output logic [chan_idx_w(NUM_AUDIO_CHANNELS)-1:0] m_chan,
   output logic                                      m_last,
   output logic                                      busy,
   output logic [OVF_CNT_WIDTH-1:0]                  overflow_count,
   output sched_state_e                              dbg_state
);

   localparam int          CW          = chan_idx_w(NUM_AUDIO_CHANNELS);
   localparam logic [1:0]  SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

   sched_state_e                  state_q, state_d;
   logic [CW-1:0]                 idx_q, idx_d;
   logic [1:0]                    settle_q, settle_d;
   logic [NUM_AUDIO_CHANNELS-1:0] mask_q;
   logic [AUDIO_WIDTH-1:0]        frame_q [NUM_AUDIO_CHANNELS];
   logic                          buf_full_q;
   logic [OVF_CNT_WIDTH-1:0]      ovf_q;

   logic [NUM_AUDIO_CHANNELS-1:0] pick_mask;
   logic [CW-1:0]                 pick_idx;
   logic                          pick_found;

   // LATCH looks at the live mask to find the first channel; STREAM walks the snapshot.
   assign pick_mask = (state_q == S_LATCH) ? chan_mask : mask_q;

   audio_chan_pick #(.N(NUM_AUDIO_CHANNELS), .W(CW)) u_pick (
      .mask     (pick_mask),
      .idx      (idx_q),
      .above    (state_q == S_STREAM),
      .next_idx (pick_idx),
      .found    (pick_found)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      case (state_q)
         S_IDLE:   if (enable && buf_ready) state_d = S_LATCH;
         S_LATCH: begin
            if (pick_found) begin
               idx_d   = pick_idx;
               state_d = S_STREAM;
            end else begin
               state_d = S_POP;
            end
         end
         // A beat transfers on a cycle where m_valid and m_ready are both high;
         // until then the presented word, channel and last flag stay put.
         S_STREAM: begin
            if (m_ready) begin
               if (pick_found) idx_d = pick_idx;
               else            state_d = S_POP;
            end
         end
         S_POP: begin
            settle_d = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == SETTLE_LAST) state_d = S_IDLE;
            else                         settle_d = settle_q + 2'd1;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         settle_q   <= '0;
         mask_q     <= '0;
         frame_q    <= '{default: '0};
         buf_full_q <= 1'b0;
         ovf_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         settle_q   <= settle_d;
         buf_full_q <= buf_full;
         if (state_q == S_LATCH) begin
            mask_q  <= chan_mask;
            frame_q <= buf_data;
         end
         if (buf_full && !buf_full_q && !(&ovf_q)) ovf_q <= ovf_q + 1'b1;
      end
   end

   // Outputs decode registered state only; m_ready never reaches them combinationally.
   assign m_valid         = (state_q == S_STREAM);
   assign m_data          = frame_q[idx_q];
   assign m_chan          = idx_q;
   assign m_last          = (state_q == S_STREAM) && !pick_found;
   assign buf_read_enable = (state_q == S_POP);
   assign busy            = (state_q != S_IDLE);
   assign overflow_count  = ovf_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_audio_in_sched.sv
// Directed bench for audio_in_sched with 4 channels: table of frames plus
// hand-written stall, overflow and reset sequences.
module tb_audio_in_sched;
   import audio_in_pkg::*;

   localparam int N   = 4;
   localparam int AW  = 24;
   localparam int OVW = 2;

   logic           sys_clk = 1'b0;
   logic           sys_rst;
   logic           enable;
   logic [N-1:0]   chan_mask;
   logic           buf_ready;
   logic           buf_full;
   logic [AW-1:0]  buf_data [N];
   logic           buf_read_enable;
   logic           m_valid;
   logic           m_ready;
   logic [AW-1:0]  m_data;
   logic [1:0]     m_chan;
   logic           m_last;
   logic           busy;
   logic [OVW-1:0] overflow_count;
   sched_state_e   dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [26:0] exp_q[$];
   logic [26:0] got_q[$];
   int          got_cyc[$];
   int          pop_cyc[$];

   typedef struct {
      logic [3:0]  mask;
      logic [95:0] data;
      int          n;
      logic [7:0]  chs;
      int          pop_rel;
      int          idle_rel;
   } vec_t;

   vec_t vecs[5];

   audio_in_sched #(
      .NUM_AUDIO_CHANNELS(N),
      .AUDIO_WIDTH(AW),
      .OVF_CNT_WIDTH(OVW)
   ) dut (
      .sys_clk         (sys_clk),
      .sys_rst         (sys_rst),
      .enable          (enable),
      .chan_mask       (chan_mask),
      .buf_ready       (buf_ready),
      .buf_full        (buf_full),
      .buf_data        (buf_data),
      .buf_read_enable (buf_read_enable),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .m_data          (m_data),
      .m_chan          (m_chan),
      .m_last          (m_last),
      .busy            (busy),
      .overflow_count  (overflow_count),
      .dbg_state       (dbg_state)
   );

   // clock / cycle counter
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // monitor: beats and pops sampled mid-cycle
   always @(negedge sys_clk) begin
      if (m_valid && m_ready) begin
         got_q.push_back({m_last, m_chan, m_data});
         got_cyc.push_back(cyc);
      end
      if (buf_read_enable) pop_cyc.push_back(cyc);
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
      pop_cyc.delete();
   endtask

   // Presents a frame at cycle t and returns with cyc = t+2 (first beat cycle).
   task automatic start_frame(input logic [3:0] mask, input logic [95:0] data, output int t);
      chan_mask = mask;
      for (int i = 0; i < N; i++) buf_data[i] = data[24*i +: 24];
      buf_ready = 1'b1;
      enable    = 1'b1;
      t = cyc;
      tick();
      buf_ready = 1'b0;
      check("busy_latch", busy, 1);
      tick();
      chan_mask = ~mask;
      for (int i = 0; i < N; i++) buf_data[i] = 24'hBAD000 | 24'(i);
   endtask

   task automatic wait_idle(output int idle_cyc);
      idle_cyc = -1;
      for (int k = 0; k < 40; k++) begin
         if (!busy) begin
            idle_cyc = cyc;
            break;
         end
         tick();
      end
   endtask

   task automatic run_vec(input vec_t v);
      int t, idle_c;
      logic [1:0] ch;
      clear_sb();
      for (int j = 0; j < v.n; j++) begin
         ch = v.chs[2*j +: 2];
         exp_q.push_back({(j == v.n - 1), ch, v.data[24*ch +: 24]});
      end
      start_frame(v.mask, v.data, t);
      wait_idle(idle_c);
      check("idle_cyc", idle_c, t + v.idle_rel);
      check("beat_count", got_q.size(), v.n);
      for (int j = 0; j < v.n && j < got_q.size(); j++) begin
         check("beat", got_q[j], exp_q[j]);
         check("beat_cyc", got_cyc[j], t + 2 + j);
      end
      check("pop_count", pop_cyc.size(), 1);
      if (pop_cyc.size() > 0) check("pop_cyc", pop_cyc[0], t + v.pop_rel);
   endtask

   initial begin
      int t, idle_c;
      logic [95:0] d1234;
      d1234 = {24'h000004, 24'h000003, 24'h000002, 24'h000001};

      vecs[0] = '{mask: 4'b1111, data: d1234, n: 4, chs: {2'd3, 2'd2, 2'd1, 2'd0}, pop_rel: 6, idle_rel: 9};
      vecs[1] = '{mask: 4'b1010, data: {24'h000040, 24'h000030, 24'h000020, 24'h000010},
                  n: 2, chs: {4'd0, 2'd3, 2'd1}, pop_rel: 4, idle_rel: 7};
      vecs[2] = '{mask: 4'b0000, data: {24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD},
                  n: 0, chs: 8'd0, pop_rel: 2, idle_rel: 5};
      vecs[3] = '{mask: 4'b0100, data: {24'h123456, 24'hABCDEF, 24'h654321, 24'h0F0F0F},
                  n: 1, chs: {6'd0, 2'd2}, pop_rel: 3, idle_rel: 6};
      vecs[4] = '{mask: 4'b1001, data: {24'hFFFFFF, 24'h555555, 24'h777777, 24'h800000},
                  n: 2, chs: {4'd0, 2'd3, 2'd0}, pop_rel: 4, idle_rel: 7};

      // reset
      sys_rst   = 1'b1;
      enable    = 1'b0;
      chan_mask = '0;
      buf_ready = 1'b0;
      buf_full  = 1'b0;
      m_ready   = 1'b1;
      for (int i = 0; i < N; i++) buf_data[i] = '0;
      repeat (3) tick();
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pop", buf_read_enable, 0);
      check("rst_m_last", m_last, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_chan", m_chan, 0);
      check("rst_ovf", overflow_count, 0);
      check("rst_state", dbg_state, S_IDLE);
      sys_rst = 1'b0;
      tick();

      // table-driven frames
      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // backpressure while ch2 is presented
      clear_sb();
      for (int j = 0; j < 4; j++) exp_q.push_back({(j == 3), 2'(j), 24'(j + 1)});
      start_frame(4'b1111, d1234, t);
      tick();
      tick();
      m_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (s > 0) tick();
         check("stall_valid", m_valid, 1);
         check("stall_chan", m_chan, 2);
         check("stall_data", m_data, 24'h000003);
         check("stall_last", m_last, 0);
      end
      m_ready = 1'b1;
      wait_idle(idle_c);
      check("stall_idle_cyc", idle_c, t + 12);
      check("stall_beat_count", got_q.size(), 4);
      for (int j = 0; j < 4 && j < got_q.size(); j++) check("stall_beat", got_q[j], exp_q[j]);
      check("stall_pop_count", pop_cyc.size(), 1);
      if (pop_cyc.size() > 0) check("stall_pop_cyc", pop_cyc[0], t + 9);

      // overflow counting with enable low
      enable = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         buf_full = 1'b1;
         tick();
         tick();
         check("ovf_count", overflow_count, (k > 3) ? 3 : k);
         buf_full = 1'b0;
         tick();
         tick();
      end
      check("ovf_idle", busy, 0);

      // reset mid-stream at ch1
      clear_sb();
      start_frame(4'b1111, d1234, t);
      tick();
      check("pre_rst_chan", m_chan, 1);
      m_ready = 1'b0;
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ovf", overflow_count, 0);
      check("mid_rst_chan", m_chan, 0);
      m_ready = 1'b1;
      repeat (8) tick();
      check("mid_rst_pops", pop_cyc.size(), 0);
      check("mid_rst_beats", got_q.size(), 1);
      run_vec(vecs[0]);

      // buf_full high across reset release counts once
      buf_full = 1'b1;
      sys_rst  = 1'b1;
      tick();
      sys_rst = 1'b0;
      check("rel_ovf_in_rst", overflow_count, 0);
      tick();
      check("rel_ovf_edge", overflow_count, 1);
      tick();
      check("rel_ovf_level", overflow_count, 1);
      buf_full = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_in_sched.md
# audio_in_sched

Frame scheduler between the multichannel I2S input buffer and the serial DSP pipeline. It waits for a complete buffered frame and snapshots all channel words. It then streams the enabled channels one word at a time over a valid/ready interface, and pops the buffer with a single read-enable pulse once the frame is consumed. It also counts buffer-overflow events for status registers.

## Interface
- NUM_AUDIO_CHANNELS, 24, channels per frame (≥2)
- AUDIO_WIDTH, 24, bits per sample word
- OVF_CNT_WIDTH, 16, width of saturating overflow counter
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  one clock; reset is synchronous and active-high
- enable  in  1  start new frames while high; an in-progress frame always completes
- chan_mask  in  NUM_AUDIO_CHANNELS  bit i=1 emits channel i; sampled only in LATCH
- buf_ready  in  1  buffer holds a frame on every channel
- buf_full  in  1  buffer overflow flag (level)
- buf_data  in  AUDIO_WIDTH x NUM_AUDIO_CHANNELS (unpacked)  head word of each channel
- buf_read_enable  out  1  one-cycle pop of all channel heads
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_data  out  AUDIO_WIDTH  sample word
- m_chan  out  $clog2(NUM_AUDIO_CHANNELS)  channel index of m_data
- m_last  out  1  final enabled channel of the frame
- busy  out  1  state != IDLE
- overflow_count  out  OVF_CNT_WIDTH  saturating count of buf_full rising edges

## Operation
- FSM states: IDLE, LATCH, STREAM, POP, SETTLE.
- IDLE: if enable && buf_ready -> LATCH.
- LATCH: register all buf_data words into the frame store and latch chan_mask.
  - If the latched mask is 0 -> POP.
  - Otherwise load idx = lowest set bit and go -> STREAM.
- STREAM: m_valid=1, m_data=frame[idx], m_chan=idx, m_last=1 iff there is no set mask bit above idx.
  - On m_valid&&m_ready: if m_last -> POP, else idx = next set bit above idx.
  - If m_ready=0, m_data, m_chan and m_last hold unchanged.
- POP: buf_read_enable=1 for exactly one cycle -> SETTLE.
- SETTLE: hold 2 cycles, covering buffer status latency, then -> IDLE. buf_ready is ignored during SETTLE.
- Exactly one buf_read_enable pulse per frame, including a mask=0 frame. No pulse is issued for an abandoned frame.
- enable, chan_mask and buf_data changes after LATCH do not affect the current frame.
- Overflow counting:
  - Register buf_full_q and increment on buf_full && !buf_full_q.
  - Hold at all-ones; never wrap.
  - Counts in every state, independent of enable.
- Reset:
  - State returns to IDLE.
  - m_valid, m_last, buf_read_enable and busy go to 0; m_data and m_chan go to 0.
  - overflow_count goes to 0 and buf_full_q to 0. A buf_full already high at release counts as one edge.
  - Reset mid-frame abandons the frame: no further beats and no pop.

## Timing
- buf_ready sampled high in IDLE at cycle t: LATCH at t+1, first m_valid at t+2.
- Throughput is one word per cycle while m_ready=1.
- Frame with k enabled channels and m_ready held high:
  - buf_read_enable at t+2+k.
  - IDLE at t+5+k; the next frame can start then, for a period of k+5 cycles.
- Frame with mask=0: buf_read_enable at t+2.
- busy is high from t+1 through the last SETTLE cycle.
- All outputs are registered, with no combinational path from m_ready to m_valid, m_data or m_chan.

## Structure
- Package audio_in_pkg:
  - sched_state_e enum.
  - CHAN_IDX_W = $clog2(NUM_AUDIO_CHANNELS) helper.
  - SETTLE_CYCLES = 2.
- Sub-module audio_chan_pick, purely combinational, instantiated once.
  - Inputs: mask and current idx. Mode: first set bit, or first set bit above idx.
  - Outputs: next_idx and found. m_last is !found for the "above idx" query.
- The frame store is a flat register array in audio_in_sched.

## Test plan
Bench parameters: NUM_AUDIO_CHANNELS=4, AUDIO_WIDTH=24, OVF_CNT_WIDTH=2.
- Mask 4'b1111, buf_data {0x000001, 0x000002, 0x000003, 0x000004}, m_ready=1, buf_ready at t -> beats (ch, data) (0,0x1) (1,0x2) (2,0x3) (3,0x4) on t+2..t+5; m_last only at t+5; one buf_read_enable at t+6; busy low at t+9.
- Mask 4'b1010 -> exactly two beats, ch1 then ch3; m_last on ch3; one pop.
- Mask 4'b1111 with m_ready=0 for 3 cycles while ch2 is presented -> ch2/0x3 held stable for 4 cycles; no duplicate or skipped beats; pop delayed by 3 cycles.
- Mask 4'b0000 -> no m_valid; buf_read_enable single pulse at t+2.
- buf_full toggled 0→1→0 five times -> overflow_count 1, 2, 3, 3, 3 (saturated); unaffected by enable=0.
- sys_rst held 1 cycle during STREAM at ch1 -> next cycle m_valid=0, busy=0, overflow_count=0; no buf_read_enable for that frame; the next buf_ready restarts at ch0.
